// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch / next-PC stage.
package cpu_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_e;

    // A control-flow target is misaligned when it is not on a word boundary.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return (lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: priority mux of JALR / JAL / taken branch / sequential,
// plus misaligned-redirect detection. Purely combinational.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic            i_branch_en,
    input  logic            i_branch_taken,
    input  logic            i_jal_en,
    input  logic            i_jalr_en,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_misalign
);

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_rel;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;

    // All sums wrap modulo 2^XLEN by construction of the operand width.
    assign w_pc_plus4 = i_pc + XLEN'(INSTR_BYTES);
    assign w_pc_rel   = i_pc + i_imm;
    assign w_jalr_sum = i_rs1_val + i_imm;
    assign w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};

    // Priority select of the next PC; only redirects are alignment-checked.
    always_comb begin
        w_target   = w_pc_plus4;
        w_redirect = 1'b0;
        if (i_jalr_en) begin
            w_target   = w_jalr_tgt;
            w_redirect = 1'b1;
        end else if (i_jal_en) begin
            w_target   = w_pc_rel;
            w_redirect = 1'b1;
        end else if (i_branch_en && i_branch_taken) begin
            w_target   = w_pc_rel;
            w_redirect = 1'b1;
        end else begin
            w_target   = w_pc_plus4;
            w_redirect = 1'b0;
        end
    end

    assign o_next_pc  = w_target;
    assign o_pc_plus4 = w_pc_plus4;
    assign o_misalign = w_redirect && is_misaligned(w_target[1:0]);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Program counter, fetch handshake sequencing and misaligned-target trap.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module fetch_pc_ctrl
    import cpu_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_en,
    input  logic            branch_taken,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rdy,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     taken_cnt
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_trap_pc;
    logic [XLEN-1:0] w_trap_pc_nxt;
    logic            r_imem_req;
    logic            r_instr_valid;
    logic            r_misalign_trap;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_misalign;

    next_pc_sel #(
        .XLEN (XLEN)
    ) u_next_pc_sel (
        .i_pc           (r_pc),
        .i_imm          (imm),
        .i_rs1_val      (rs1_val),
        .i_branch_en    (branch_en),
        .i_branch_taken (branch_taken),
        .i_jal_en       (jal_en),
        .i_jalr_en      (jalr_en),
        .o_next_pc      (w_next_pc),
        .o_pc_plus4     (w_pc_plus4),
        .o_misalign     (w_misalign)
    );

    // Next-state, next-PC and trap-capture decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_trap_pc_nxt = r_trap_pc;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_rdy) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    w_state_nxt = ST_EXEC;
                end else if (w_misalign) begin
                    w_state_nxt   = ST_TRAP;
                    w_trap_pc_nxt = r_pc;
                end else begin
                    w_state_nxt = ST_FETCH;
                    w_pc_nxt    = w_next_pc;
                end
            end
            ST_TRAP: begin
                w_state_nxt = ST_FETCH;
                w_pc_nxt    = TRAP_VECTOR;
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_pc_nxt    = RESET_VECTOR;
            end
        endcase
    end

    // State, PC, trap PC and registered state-decoded outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_BOOT;
            r_pc            <= RESET_VECTOR;
            r_trap_pc       <= {XLEN{1'b0}};
            r_imem_req      <= 1'b0;
            r_instr_valid   <= 1'b0;
            r_misalign_trap <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_trap_pc       <= w_trap_pc_nxt;
            r_imem_req      <= (w_state_nxt == ST_FETCH);
            r_instr_valid   <= (w_state_nxt == ST_EXEC);
            r_misalign_trap <= (w_state_nxt == ST_TRAP);
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_taken_cnt;
    logic        w_br_retire;

    assign w_br_retire = (r_state == ST_EXEC) && !stall && branch_en && !w_misalign;

    // Retired-branch statistics; both counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= 32'd0;
            r_taken_cnt  <= 32'd0;
        end else begin
            if (w_br_retire) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end else begin
                r_branch_cnt <= r_branch_cnt;
            end
            if (w_br_retire && branch_taken) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end else begin
                r_taken_cnt <= r_taken_cnt;
            end
        end
    end

    assign branch_cnt = r_branch_cnt;
    assign taken_cnt  = r_taken_cnt;
`else
    assign branch_cnt = 32'd0;
    assign taken_cnt  = 32'd0;
`endif

    assign pc            = r_pc;
    assign imem_addr     = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign imem_req      = r_imem_req;
    assign instr_valid   = r_instr_valid;
    assign misalign_trap = r_misalign_trap;
    assign trap_pc       = r_trap_pc;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios followed by
// randomized stimulus, all compared against a behavioural reference model.
module tb_fetch_pc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        branch_en, branch_taken, jal_en, jalr_en, stall, imem_rdy;
    logic [31:0] imm, rs1_val;
    logic        imem_req, instr_valid, misalign_trap;
    logic [31:0] imem_addr, pc, pc_plus4, trap_pc, branch_cnt, taken_cnt;

    int n_checks;
    int n_errors;

    // Reference model: phase 0=boot, 1=fetching, 2=executing, 3=trap pulse.
    int          m_phase;
    logic [31:0] m_pc, m_trap_pc, m_bcnt, m_tcnt;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_en     (branch_en),
        .branch_taken  (branch_taken),
        .jal_en        (jal_en),
        .jalr_en       (jalr_en),
        .imm           (imm),
        .rs1_val       (rs1_val),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdy      (imem_rdy),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .misalign_trap (misalign_trap),
        .trap_pc       (trap_pc),
        .branch_cnt    (branch_cnt),
        .taken_cnt     (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_pc      = 32'h0000_0000;
        m_trap_pc = 32'h0000_0000;
        m_bcnt    = 32'd0;
        m_tcnt    = 32'd0;
    endtask

    // Apply one clock edge's worth of architectural rules to the model.
    task automatic model_advance();
        logic [31:0] tgt;
        logic        redir;
        case (m_phase)
            0: m_phase = 1;
            1: if (imem_rdy) m_phase = 2;
            2: if (!stall) begin
                redir = 1'b1;
                if (jalr_en)                       tgt = (rs1_val + imm) & 32'hFFFF_FFFE;
                else if (jal_en)                   tgt = m_pc + imm;
                else if (branch_en && branch_taken) tgt = m_pc + imm;
                else begin
                    tgt   = m_pc + 32'd4;
                    redir = 1'b0;
                end
                if (redir && (tgt % 32'd4) != 32'd0) begin
                    m_trap_pc = m_pc;
                    m_phase   = 3;
                end else begin
                    m_pc    = tgt;
                    m_phase = 1;
                    if (branch_en) begin
                        m_bcnt = m_bcnt + 32'd1;
                        if (branch_taken) m_tcnt = m_tcnt + 32'd1;
                    end
                end
            end
            default: begin
                m_pc    = 32'h0000_0100;
                m_phase = 1;
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("imem_req",      {31'd0, imem_req},      {31'd0, m_phase == 1});
        check_val("instr_valid",   {31'd0, instr_valid},   {31'd0, m_phase == 2});
        check_val("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_phase == 3});
        check_val("pc",            pc,        m_pc);
        check_val("imem_addr",     imem_addr, m_pc);
        check_val("pc_plus4",      pc_plus4,  m_pc + 32'd4);
        check_val("trap_pc",       trap_pc,   m_trap_pc);
`ifdef BRANCH_STATS_EN
        check_val("branch_cnt",    branch_cnt, m_bcnt);
        check_val("taken_cnt",     taken_cnt,  m_tcnt);
`else
        check_val("branch_cnt",    branch_cnt, 32'd0);
        check_val("taken_cnt",     taken_cnt,  32'd0);
`endif
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge.
    task automatic step(input logic be, input logic bt, input logic je, input logic jre,
                        input logic [31:0] im, input logic [31:0] rs1,
                        input logic st, input logic rdy);
        branch_en = be; branch_taken = bt; jal_en = je; jalr_en = jre;
        imm = im; rs1_val = rs1; stall = st; imem_rdy = rdy;
        model_advance();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, rdy);
    endtask

    // Assert reset between edges and confirm it acts without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val({tag, "_pc"},     pc,         32'h0000_0000);
        check_val({tag, "_req"},    {31'd0, imem_req},    32'd0);
        check_val({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
        check_val({tag, "_bcnt"},   branch_cnt, 32'd0);
        check_val({tag, "_tcnt"},   taken_cnt,  32'd0);
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        branch_en = 1'b0; branch_taken = 1'b0; jal_en = 1'b0; jalr_en = 1'b0;
        imm = 32'd0; rs1_val = 32'd0; stall = 1'b0; imem_rdy = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Sequential flow: BOOT, then fetches at 0,4,8,C.
        idle(1'b1); check_val("seq_addr0", imem_addr, 32'h0);
        idle(1'b1);
        idle(1'b1); check_val("seq_addr4", imem_addr, 32'h4);
        idle(1'b1);
        idle(1'b1); check_val("seq_addr8", imem_addr, 32'h8);
        idle(1'b1);
        idle(1'b1); check_val("seq_addrC", imem_addr, 32'hC);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h34, 32'd0, 1'b0, 1'b1);
        check_val("jal_to_40", imem_addr, 32'h40);
        idle(1'b1);
        // Taken branch backwards.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1);
        check_val("br_taken", imem_addr, 32'h30);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1);
        idle(1'b1);
        // Not-taken branch falls through.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1);
        check_val("br_not_taken", imem_addr, 32'h44);
        idle(1'b1);
        // JALR beats JAL; bit 0 cleared.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h1001, 1'b0, 1'b1);
        check_val("jalr_prio", imem_addr, 32'h1010);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_F070, 32'd0, 1'b0, 1'b1);
        check_val("jal_to_80", imem_addr, 32'h80);
        idle(1'b1);
        // Misaligned JAL traps.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h6, 32'd0, 1'b0, 1'b1);
        check_val("trap_pulse", {31'd0, misalign_trap}, 32'd1);
        check_val("trap_pc_80", trap_pc, 32'h80);
        idle(1'b0);
        check_val("trap_vec", imem_addr, 32'h100);
        check_val("trap_end", {31'd0, misalign_trap}, 32'd0);
        // Slow memory then stalled taken branch.
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0, 1'b1, 1'b1);
        check_val("stall_pc", pc, 32'h100);
        check_val("stall_valid", {31'd0, instr_valid}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0, 1'b0, 1'b1);
        check_val("after_stall", imem_addr, 32'h108);
`ifdef BRANCH_STATS_EN
        check_val("stat_branches", branch_cnt, 32'd3);
        check_val("stat_taken",    taken_cnt,  32'd2);
`endif
        idle(1'b1);
        // Wrap-around at the top of the address space.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hC, 32'hFFFF_FFF0, 1'b0, 1'b1);
        check_val("wrap_pc", pc, 32'hFFFF_FFFC);
        check_val("wrap_plus4", pc_plus4, 32'h0);
        idle(1'b1);
        idle(1'b1);
        check_val("wrap_next", imem_addr, 32'h0);
        idle(1'b1);
        async_reset("rst_exec");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r_imm;
            case ($urandom_range(0, 3))
                0: r_imm = ($urandom_range(0, 63) << 2) - 32'd128;
                1: r_imm = $urandom_range(0, 15) - 32'd8;
                2: r_imm = $urandom;
                default: r_imm = 32'd0;
            endcase
            step(($urandom % 3) == 0, $urandom % 2, ($urandom % 8) == 0, ($urandom % 8) == 0,
                 r_imm, ($urandom % 2) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                 ($urandom % 4) == 0, ($urandom % 3) != 0);
            if ((i % 700) == 350) async_reset("rst_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Program-counter and next-PC stage of the single-cycle CPU. It consumes the branch decoder's taken flag together with the jump decodes, and computes the next PC. It also sequences instruction-memory fetch with a request/ready handshake and traps misaligned control-flow targets. Its outputs drive the instruction memory, the register-file link write (pc_plus4) and the datapath PC operand.

Parameters:
XLEN, 32, data/address width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
branch_en  in  1  current instruction is a conditional branch
branch_taken  in  1  taken flag from branch decoder
jal_en  in  1  current instruction is JAL
jalr_en  in  1  current instruction is JALR
imm  in  XLEN  sign-extended immediate
rs1_val  in  XLEN  rs1 operand, used by JALR
stall  in  1  hold the current instruction; no PC update
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address (equals pc)
imem_rdy  in  1  instruction memory returns the instruction this cycle
pc  out  XLEN  current PC
pc_plus4  out  XLEN  pc + 4, used as the link value
instr_valid  out  1  fetched instruction is executing this cycle
misalign_trap  out  1  one-cycle pulse on a misaligned target
trap_pc  out  XLEN  PC of the faulting instruction
branch_cnt  out  32  conditional branches retired (feature only)
taken_cnt  out  32  taken branches retired (feature only)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR, state=BOOT.
  - imem_req=0, instr_valid=0, misalign_trap=0, trap_pc=0, counters=0.
- FSM states: BOOT, FETCH, EXEC, TRAP.
  - BOOT: one idle cycle after reset release; imem_req=0; next state FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Stays in FETCH while imem_rdy=0. On imem_rdy=1, next state EXEC. stall is ignored in FETCH.
  - EXEC: instr_valid=1, imem_req=0.
    - stall=1: remain in EXEC; pc held; instr_valid stays 1.
    - stall=0 and the target is aligned: pc<=next_pc; next state FETCH.
    - stall=0 and a redirect target is misaligned: next state TRAP; pc is not updated.
  - TRAP: misalign_trap=1 for exactly one cycle; trap_pc holds the faulting pc (captured on the EXEC->TRAP edge); pc<=TRAP_VECTOR; next state FETCH.
- next_pc priority (highest first):
  1. jalr_en: (rs1_val+imm) with bit 0 cleared
  2. jal_en: pc+imm
  3. branch_en && branch_taken: pc+imm
  4. otherwise: pc+4
  - branch_taken is ignored when branch_en=0.
  - When several enables are asserted together, the priority above applies with no error.
- Alignment: misaligned means a redirect target has bits [1:0] != 0. Checked only for redirects; pc+4 is never checked.
- Arithmetic: all additions are modulo 2^XLEN.
  - pc=32'hFFFF_FFFC with sequential flow gives next pc 32'h0000_0000.
  - Negative imm wraps the same way.
- pc_plus4 = pc+4, combinational and always valid.
- Reset asserted mid-FETCH or mid-EXEC: immediate return to the reset values; any outstanding fetch is abandoned. The memory must tolerate a dropped imem_req.
- Latency: minimum 2 cycles per instruction (FETCH with imem_rdy=1, then EXEC).

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - branch_cnt increments on each EXEC cycle with stall=0, branch_en=1 and no trap.
  - taken_cnt increments on the same condition when branch_taken=1 as well.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports remain and are tied to 0; no counter flops are inferred.

Decomposition:
- Shared package cpu_pkg:
  - FSM state typedef (BOOT/FETCH/EXEC/TRAP, 2 bits)
  - constants INSTR_BYTES=4, RESET_VECTOR_DEF, TRAP_VECTOR_DEF
- One sub-module: next_pc_sel. It is purely combinational: priority mux, adders, bit-0 clear and misalign detect.
- The FSM and registers stay in the top module.

Test Plan:
- Reset release, imem_rdy=1 always, no enables -> imem_addr sequence 0,4,8,C; instr_valid alternates 0/1; BOOT cycle precedes the first fetch.
- pc=0x40, branch_en=1, branch_taken=1, imm=-16 -> next fetch at 0x30. Same with branch_taken=0 -> next fetch at 0x44.
- jalr_en=1, jal_en=1, rs1_val=0x1001, imm=0x10 -> jalr wins; next pc 0x1010 (bit 0 cleared).
- pc=0x80, jal_en=1, imm=0x6 -> misalign_trap pulses 1 cycle, trap_pc=0x80, next fetch at 0x100.
- imem_rdy held 0 for 3 cycles, then stall=1 for 2 EXEC cycles -> imem_req held 3 cycles; pc constant; instr_valid stays 1 through the stall; pc advances only afterwards.
- With BRANCH_STATS_EN: 3 branches retired, 2 taken, one of them stalled for 2 cycles -> branch_cnt=3, taken_cnt=2. Assert rst_n mid-EXEC -> both counters and pc return to 0 and RESET_VECTOR asynchronously.
